// File: rtl/relogio_pkg.sv
// Shared types and BCD helpers for the hh:mm time-set controller.
package relogio_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    LOAD  = 2'd3
  } state_e;

  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;

  // BCD hours/minutes payload handed to the clock core on LD.
  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hm_bcd_t;

  function automatic int unsigned bcd_hours(hm_bcd_t t);
    return 32'(t.h1) * 32'd10 + 32'(t.h0);
  endfunction

  function automatic int unsigned bcd_minutes(hm_bcd_t t);
    return 32'(t.m1) * 32'd10 + 32'(t.m0);
  endfunction

  // Hours +1 with wrap 23 -> 00; minutes untouched.
  function automatic hm_bcd_t bcd_inc_hours(hm_bcd_t t);
    hm_bcd_t r;
    r = t;
    if (bcd_hours(t) >= HOUR_MAX) begin
      r.h1 = 2'd0;
      r.h0 = 4'd0;
    end else if (t.h0 == 4'd9) begin
      r.h0 = 4'd0;
      r.h1 = t.h1 + 2'd1;
    end else begin
      r.h0 = t.h0 + 4'd1;
    end
    return r;
  endfunction

  // Minutes +1 with wrap 59 -> 00; no carry into hours.
  function automatic hm_bcd_t bcd_inc_minutes(hm_bcd_t t);
    hm_bcd_t r;
    r = t;
    if (bcd_minutes(t) >= MIN_MAX) begin
      r.m1 = 4'd0;
      r.m0 = 4'd0;
    end else if (t.m0 == 4'd9) begin
      r.m0 = 4'd0;
      r.m1 = t.m1 + 4'd1;
    end else begin
      r.m0 = t.m0 + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/relogio_btn_edge.sv
// Rising-edge press detector for one button; with RELOGIO_AUTO_REPEAT_EN the
// instance built with REPEAT_EN also emits hold-to-repeat pulses.
module relogio_btn_edge
  import relogio_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter bit          REPEAT_EN     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  input  logic en_i,
  input  logic clr_i,
  output logic press_c_o,
  output logic rep_c_o
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
    end
  end

  assign press_c_o = btn_i & ~btn_q;

`ifdef RELOGIO_AUTO_REPEAT_EN
  if (REPEAT_EN) begin : g_rep
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CW       = $clog2(HOLD_MAX + 1);

    logic [CW-1:0] hold_q, hold_d;
    logic [CW-1:0] target;
    logic          active_q, active_d;
    logic          armed_q, armed_d;

    // First repeat after REPEAT_DELAY, then the counter restarts per period.
    assign target  = armed_q ? CW'(REPEAT_PERIOD) : CW'(REPEAT_DELAY);
    assign rep_c_o = active_q & btn_i & (hold_q == target);

    always_comb begin
      hold_d   = hold_q;
      active_d = active_q;
      armed_d  = armed_q;
      if (!en_i || clr_i || !btn_i) begin
        hold_d   = '0;
        active_d = 1'b0;
        armed_d  = 1'b0;
      end else if (press_c_o) begin
        hold_d   = CW'(1);
        active_d = 1'b1;
        armed_d  = 1'b0;
      end else if (active_q) begin
        if (rep_c_o) begin
          hold_d  = CW'(1);
          armed_d = 1'b1;
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        hold_q   <= '0;
        active_q <= 1'b0;
        armed_q  <= 1'b0;
      end else begin
        hold_q   <= hold_d;
        active_q <= active_d;
        armed_q  <= armed_d;
      end
    end
  end else begin : g_no_rep
    assign rep_c_o = 1'b0;
  end
`else
  assign rep_c_o = 1'b0;
`endif

  localparam int unsigned unused_rep_cfg = REPEAT_DELAY + REPEAT_PERIOD + 32'(REPEAT_EN);
  logic unused_ok;
  assign unused_ok = ^{en_i, clr_i};

endmodule

// File: rtl/relogio_ajuste_ctrl.sv
// Time-set controller: mode/inc buttons edit BCD hh:mm and pulse LD to the clock core.
// Optional auto-repeat on a held inc button: define RELOGIO_AUTO_REPEAT_EN.
module relogio_ajuste_ctrl
  import relogio_pkg::*;
#(
  parameter int unsigned BLINK_DIV      = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned REPEAT_DELAY   = 50_000_000,
  parameter int unsigned REPEAT_PERIOD  = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       LD,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       editing,
  output logic       sel_h,
  output logic       sel_m,
  output logic       blink
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BW = $clog2(BLINK_DIV + 1);

  state_e        state_q, state_d;
  hm_bcd_t       edit_q, edit_d;
  hm_bcd_t       commit_q, commit_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;
  logic          ld_q, ld_d;
  logic          editing_q, editing_d;
  logic          sel_h_q, sel_h_d;
  logic          sel_m_q, sel_m_d;

  logic mode_press, inc_press, inc_rep, mode_rep_unused;
  logic edit_en, state_chg, inc_evt, any_press, tmo_expired;

  assign edit_en     = (state_q == SET_H) || (state_q == SET_M);
  assign state_chg   = (state_d != state_q);
  assign inc_evt     = inc_press | inc_rep;
  assign any_press   = mode_press | inc_evt;
  assign tmo_expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  relogio_btn_edge #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN    (1'b0)
  ) u_mode_edge (
    .clk      (clk),
    .reset    (reset),
    .btn_i    (btn_mode),
    .en_i     (edit_en),
    .clr_i    (state_chg),
    .press_c_o(mode_press),
    .rep_c_o  (mode_rep_unused)
  );

  relogio_btn_edge #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN    (1'b1)
  ) u_inc_edge (
    .clk      (clk),
    .reset    (reset),
    .btn_i    (btn_inc),
    .en_i     (edit_en),
    .clr_i    (state_chg),
    .press_c_o(inc_press),
    .rep_c_o  (inc_rep)
  );

  // Next state, edit datapath, timeout/blink timers and registered outputs.
  always_comb begin
    state_d   = state_q;
    edit_d    = edit_q;
    commit_d  = commit_q;
    tmo_d     = tmo_q;
    bcnt_d    = bcnt_q;
    blink_d   = blink_q;

    unique case (state_q)
      RUN: begin
        if (mode_press) state_d = SET_H;
      end
      SET_H: begin
        if (mode_press) begin
          state_d = SET_M;
        end else if (inc_evt) begin
          edit_d = bcd_inc_hours(edit_q);
        end else if (tmo_expired) begin
          state_d = RUN;
          edit_d  = commit_q;
        end
      end
      SET_M: begin
        if (mode_press) begin
          state_d  = LOAD;
          commit_d = edit_q;
        end else if (inc_evt) begin
          edit_d = bcd_inc_minutes(edit_q);
        end else if (tmo_expired) begin
          state_d = RUN;
          edit_d  = commit_q;
        end
      end
      LOAD: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    editing_d = (state_d == SET_H) || (state_d == SET_M);
    sel_h_d   = (state_d == SET_H);
    sel_m_d   = (state_d == SET_M);
    ld_d      = (state_d == LOAD);

    // Blink restarts high on each field entry; timeout restarts on any press.
    if (!editing_d) begin
      tmo_d   = '0;
      bcnt_d  = '0;
      blink_d = 1'b0;
    end else if (state_chg) begin
      tmo_d   = '0;
      bcnt_d  = '0;
      blink_d = 1'b1;
    end else begin
      tmo_d = any_press ? '0 : tmo_q + TW'(1);
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      edit_q    <= '0;
      commit_q  <= '0;
      tmo_q     <= '0;
      bcnt_q    <= '0;
      blink_q   <= 1'b0;
      ld_q      <= 1'b0;
      editing_q <= 1'b0;
      sel_h_q   <= 1'b0;
      sel_m_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      edit_q    <= edit_d;
      commit_q  <= commit_d;
      tmo_q     <= tmo_d;
      bcnt_q    <= bcnt_d;
      blink_q   <= blink_d;
      ld_q      <= ld_d;
      editing_q <= editing_d;
      sel_h_q   <= sel_h_d;
      sel_m_q   <= sel_m_d;
    end
  end

  assign LD      = ld_q;
  assign H_in1   = edit_q.h1;
  assign H_in0   = edit_q.h0;
  assign M_in1   = edit_q.m1;
  assign M_in0   = edit_q.m0;
  assign editing = editing_q;
  assign sel_h   = sel_h_q;
  assign sel_m   = sel_m_q;
  assign blink   = blink_q;

endmodule
